// File: rtl/ysyx_22050710_sram_responder_if.sv
// SRAM-like req/addr_ok/data_ok bus between a core port and its memory.
// The core drives the master side; the memory responder is the slave.
interface ysyx_22050710_sram_responder_if #(
    parameter int ADDR_WD  = 32,
    parameter int DATA_WD  = 64,
    parameter int WMASK_WD = 8
);
    logic                req;
    logic                wr;
    logic [1:0]          size;
    logic [ADDR_WD-1:0]  addr;
    logic [WMASK_WD-1:0] wstrb;
    logic [DATA_WD-1:0]  wdata;
    logic                addr_ok;
    logic                data_ok;
    logic [DATA_WD-1:0]  rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/ysyx_22050710_sram_responder.sv
// In-order SRAM responder: word RAM plus a FIFO of timed responses.
// Data is captured at acceptance and released LATENCY cycles later.
module ysyx_22050710_sram_responder #(
    parameter int                      SRAM_ADDR_WD  = 32,
    parameter int                      SRAM_DATA_WD  = 64,
    parameter int                      SRAM_WMASK_WD = 8,
    parameter int                      MEM_ADDR_WD   = 12,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int                      LATENCY       = 1,
    parameter int                      FIFO_DEPTH    = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    ysyx_22050710_sram_responder_if.slave bus,
    output logic [$clog2(FIFO_DEPTH):0]   o_outstanding
);
    localparam int         PTR_WD     = $clog2(FIFO_DEPTH);
    localparam int         CNT_WD     = PTR_WD + 1;
    localparam logic [2:0] TIMER_INIT = 3'(LATENCY - 1);

    logic [SRAM_DATA_WD-1:0] mem [2**MEM_ADDR_WD];

    logic [SRAM_DATA_WD-1:0] fifo_data  [FIFO_DEPTH];
    logic [2:0]              fifo_timer [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_valid;
    logic [PTR_WD-1:0]       wr_ptr;
    logic [PTR_WD-1:0]       rd_ptr;
    logic [CNT_WD-1:0]       count;

    logic                    full;
    logic                    push;
    logic                    pop;
    logic [SRAM_ADDR_WD-1:0] offset;
    logic [MEM_ADDR_WD-1:0]  index;
    logic                    sink_unused;

    // Out-of-range addresses wrap; byte offset and size are the core's job.
    assign offset      = bus.addr - BASE_ADDR;
    assign index       = offset[MEM_ADDR_WD+2:3];
    assign sink_unused = ^{offset[2:0],
                           offset[SRAM_ADDR_WD-1:MEM_ADDR_WD+3],
                           bus.size};

    // A pop in the same cycle does not free a slot for a new request.
    assign full          = count == CNT_WD'(FIFO_DEPTH);
    assign bus.addr_ok   = i_rst & bus.req & ~full;
    assign push          = bus.req & bus.addr_ok;
    assign bus.data_ok   = fifo_valid[rd_ptr] & (fifo_timer[rd_ptr] == 3'd0);
    assign pop           = bus.data_ok;
    assign bus.rdata     = bus.data_ok ? fifo_data[rd_ptr] : '0;
    assign o_outstanding = count;

    // Byte-masked RAM write at acceptance; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (push && bus.wr) begin
            for (int b = 0; b < SRAM_WMASK_WD; b++) begin
                if (bus.wstrb[b]) begin
                    mem[index][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response FIFO: timers count down, head pops when its timer hits zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fifo_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (fifo_valid[i] && fifo_timer[i] != 3'd0) begin
                    fifo_timer[i] <= fifo_timer[i] - 3'd1;
                end
            end
            if (pop) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo_valid[wr_ptr] <= 1'b1;
                fifo_timer[wr_ptr] <= TIMER_INIT;
                fifo_data[wr_ptr]  <= bus.wr ? '0 : mem[index];
                wr_ptr             <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Parameter legality and read-strobe hygiene.
    a_latency : assert property (@(posedge i_clk)
        LATENCY >= 1 && LATENCY <= 7);
    a_wstrb : assert property (@(posedge i_clk) disable iff (!i_rst)
        (bus.req && !bus.wr) |-> bus.wstrb == '0);
endmodule

// File: tb/tb_ysyx_22050710_sram_responder.sv
// Bench for the SRAM responder: vector table plus hand sequences,
// with a queue of expected responses checked against data_ok pulses.
module tb_ysyx_22050710_sram_responder;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [1:0] a_out;
    logic [1:0] b_out;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    vec_t tbl[12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050710_sram_responder_if a_if ();
    ysyx_22050710_sram_responder_if b_if ();

    ysyx_22050710_sram_responder #(.LATENCY(1), .FIFO_DEPTH(2)) dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (a_if),
        .o_outstanding (a_out)
    );

    ysyx_22050710_sram_responder #(.LATENCY(3), .FIFO_DEPTH(2)) dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (b_if),
        .o_outstanding (b_out)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit on_b, input logic req, input vec_t v);
        if (on_b) begin
            b_if.req = req; b_if.wr = v.wr; b_if.size = 2'd3;
            b_if.addr = v.addr; b_if.wstrb = v.strb; b_if.wdata = v.wdata;
        end else begin
            a_if.req = req; a_if.wr = v.wr; a_if.size = 2'd3;
            a_if.addr = v.addr; a_if.wstrb = v.strb; a_if.wdata = v.wdata;
        end
    endtask

    // Present one request until accepted; record its expected response.
    task automatic issue(input bit on_b, input vec_t v, output int waited);
        logic ok;
        vec_t idle;
        idle = '{1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0};
        waited = 0;
        drive(on_b, 1'b1, v);
        do begin
            @(negedge clk);
            waited++;
            ok = on_b ? b_if.addr_ok : a_if.addr_ok;
        end while (!ok && waited < 20);
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
        else if (on_b) qb.push_back('{v.exp, cyc + 3});
        else qa.push_back('{v.exp, cyc + 1});
        @(posedge clk);
        #1;
        drive(on_b, 1'b0, idle);
    endtask

    task automatic drain();
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            check("drain_timeout", 64'(qa.size() + qb.size()), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: order, exact cycle, data, and idle rdata.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_if.data_ok) begin
                if (qa.size() == 0) begin
                    check("a_spurious_data_ok", 64'(1), 64'(0));
                end else begin
                    ea = qa.pop_front();
                    check("a_data_ok_cycle", 64'(cyc), 64'(ea.due));
                    check("a_rdata", a_if.rdata, ea.data);
                end
            end else begin
                check("a_idle_rdata", a_if.rdata, 64'h0);
                if (qa.size() != 0 && qa[0].due < cyc) begin
                    check("a_missing_data_ok", 64'(0), 64'(1));
                    void'(qa.pop_front());
                end
            end
            if (b_if.data_ok) begin
                if (qb.size() == 0) begin
                    check("b_spurious_data_ok", 64'(1), 64'(0));
                end else begin
                    eb = qb.pop_front();
                    check("b_data_ok_cycle", 64'(cyc), 64'(eb.due));
                    check("b_rdata", b_if.rdata, eb.data);
                end
            end else begin
                check("b_idle_rdata", b_if.rdata, 64'h0);
                if (qb.size() != 0 && qb[0].due < cyc) begin
                    check("b_missing_data_ok", 64'(0), 64'(1));
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   sel;
        vec_t v;
        logic [63:0] wd[3];
        logic [63:0] bw[2];
        logic        bp_ok[6];
        logic [1:0]  bp_out[6];

        tbl[0]  = '{1'b1, 32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
        tbl[1]  = '{1'b0, 32'h8000_0008, 8'h00, 64'h0, 64'h1122_3344_5566_7788};
        tbl[2]  = '{1'b1, 32'h8000_0000, 8'hFF, 64'h0, 64'h0};
        tbl[3]  = '{1'b1, 32'h8000_0000, 8'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        tbl[4]  = '{1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_FFFF_0000};
        tbl[5]  = '{1'b1, 32'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        tbl[6]  = '{1'b1, 32'h8000_0010, 8'h81, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        tbl[7]  = '{1'b1, 32'h8000_0010, 8'h00, 64'h0, 64'h0};
        tbl[8]  = '{1'b0, 32'h8000_0010, 8'h00, 64'h0, 64'hFF23_4567_89AB_CDFF};
        tbl[9]  = '{1'b1, 32'h8000_8008, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF, 64'h0};
        tbl[10] = '{1'b0, 32'h8000_0008, 8'h00, 64'h0, 64'hCAFE_BABE_DEAD_BEEF};
        tbl[11] = '{1'b0, 32'h8000_0006, 8'h00, 64'h0, 64'h0000_0000_FFFF_0000};

        wd = '{64'h0000_0000_FFFF_0000, 64'hCAFE_BABE_DEAD_BEEF,
               64'hFF23_4567_89AB_CDFF};
        bw = '{64'hA5A5_0000_1111_2222, 64'h5A5A_FFFF_3333_4444};
        bp_ok  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bp_out = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

        // Reset held two cycles with a request pending on both ports.
        rst = 1'b0;
        v = '{1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0};
        drive(1'b0, 1'b1, v);
        drive(1'b1, 1'b1, v);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_a_addr_ok", 64'(a_if.addr_ok), 64'(0));
        check("rst_a_data_ok", 64'(a_if.data_ok), 64'(0));
        check("rst_a_rdata", a_if.rdata, 64'h0);
        check("rst_a_outstanding", 64'(a_out), 64'(0));
        check("rst_b_addr_ok", 64'(b_if.addr_ok), 64'(0));
        check("rst_b_outstanding", 64'(b_out), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, v);
        drive(1'b1, 1'b0, v);
        @(posedge clk);
        #1;

        // Back-to-back vector table: each accepted at first offer.
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, tbl[i], w);
            check("tbl_first_offer", 64'(w), 64'(1));
        end

        // Eight streaming reads at full rate.
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, 32'h8000_0000 + 32'(8 * (i % 3)), 8'h00, 64'h0,
                  wd[i % 3]};
            issue(1'b0, v, w);
            check("stream_first_offer", 64'(w), 64'(1));
        end
        drain();
        check("a_outstanding_idle", 64'(a_out), 64'(0));

        // Preload two words on the slow port.
        issue(1'b1, '{1'b1, 32'h8000_0000, 8'hFF, bw[0], 64'h0}, w);
        issue(1'b1, '{1'b1, 32'h8000_0008, 8'hFF, bw[1], 64'h0}, w);
        drain();

        // Request held six cycles against a two-deep, three-cycle FIFO.
        sel = 0;
        v = '{1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0};
        drive(1'b1, 1'b1, v);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_addr_ok", 64'(b_if.addr_ok), 64'(bp_ok[c]));
            check("bp_outstanding", 64'(b_out), 64'(bp_out[c]));
            if (b_if.addr_ok) begin
                qb.push_back('{bw[sel], cyc + 3});
                sel = 1 - sel;
            end
            @(posedge clk);
            #1;
            b_if.addr = 32'h8000_0000 + 32'(8 * sel);
        end
        b_if.req = 1'b0;
        drain();

        // Reset with two reads in flight drops both responses.
        issue(1'b1, '{1'b0, 32'h8000_0000, 8'h00, 64'h0, bw[0]}, w);
        issue(1'b1, '{1'b0, 32'h8000_0008, 8'h00, 64'h0, bw[1]}, w);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("drop_data_ok", 64'(b_if.data_ok), 64'(0));
            check("drop_outstanding", 64'(b_out), 64'(0));
        end
        @(posedge clk);
        #1;

        // RAM contents persist across reset on both ports.
        issue(1'b1, '{1'b0, 32'h8000_0008, 8'h00, 64'h0, bw[1]}, w);
        issue(1'b0, '{1'b0, 32'h8000_0010, 8'h00, 64'h0, wd[2]}, w);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
